svc_rv_dmem_resp: RTL and testbench
===================================

// Module: svc_rv_dmem_resp
// PURPOSE
// Data-memory responder for the svc_rv core dmem port: the slave end of
// dmem_ren/raddr/rdata and dmem_we/waddr/wdata/wstrb. Provides word memory
// with BRAM timing (1-cycle registered read) and bounded pseudo-random stall
// injection on dmem_stall. Used in SoC sims and stall-config regressions.
// PARAMETERS
// AW         10        word-address bits; memory depth 2**AW words
// MAX_STALL  2         max consecutive stall cycles per request, 1..4
// LFSR_SEED  16'hACE1  stall LFSR reset value, must be nonzero
// PORTS
// clk          in   1   clock
// rst_n        in   1   synchronous reset, active low
// stall_en     in   1   1 = stall injection enabled, 0 = never stall
// dmem_ren     in   1   read request
// dmem_raddr   in   32  read byte address
// dmem_rdata   out  32  read data, registered
// dmem_we      in   1   write request
// dmem_waddr   in   32  write byte address
// dmem_wdata   in   32  write data
// dmem_wstrb   in   4   byte enables, bit i -> wdata[8i+7:8i]
// dmem_stall   out  1   responder busy; core holds request while high
// stall_cycles out  16  saturating count of cycles with dmem_stall=1
// BEHAVIOUR
// - One clock, clk; rst_n synchronous active-low.
// - Reset: dmem_rdata=0, dmem_stall=0, stall_cycles=0, FSM=IDLE,
//   lfsr=LFSR_SEED. Memory contents are not reset.
// - Index = addr[AW+1:2]; addr[1:0] and addr[31:AW+2] ignored (aliasing).
// - req = dmem_ren | dmem_we. Accepted = req & !dmem_stall.
// - Write: on accepted we, lanes with wstrb=1 update at clock edge.
// - Read: on accepted ren, dmem_rdata <= mem[ridx] at edge (1-cycle
//   latency). Otherwise dmem_rdata holds, including all stall cycles.
// - Same-word read+write in one accepted cycle: read-first (old data).
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle after reset.
// - pick = stall_en & lfsr[0]; len = min(lfsr[2:1]+1, MAX_STALL).
// - FSM (dmem_stall is combinational from state and inputs):
//   IDLE : stall = req & pick. If so, cnt<=len-1; next = (len==1)?GRANT:STALL.
//          Else stall=0, request accepted, stay IDLE.
//   STALL: stall=1; cnt<=cnt-1; next = (cnt==1)?GRANT:STALL.
//   GRANT: stall=0; held request accepted unconditionally; next IDLE.
// - Max consecutive stall cycles = MAX_STALL; GRANT always follows.
// - Request dropped during STALL (contract violation): FSM still runs to
//   GRANT then IDLE; no access performed unless req present in GRANT.
// - stall_en deasserted mid-stall: current sequence completes.
// - stall_cycles increments each cycle dmem_stall=1, saturates at 16'hFFFF.
// - Reset mid-stall: next cycle FSM=IDLE, dmem_stall=0, rdata=0.
// TESTING
// - stall_en=0; write 32'hDEADBEEF, wstrb 4'hF @0x10; read 0x10
//   -> rdata=32'hDEADBEEF one cycle after read, stall never high.
// - mem word 0x20=0; write 32'h11223344 wstrb 4'b0101 @0x20; read
//   -> 32'h00220044.
// - AW=10; write 32'hCAFEF00D @0x10; read 0x1010 and 0x13 -> 32'hCAFEF00D.
// - stall_en=1, seed giving pick with len=2, ren held: stall=1 two cycles,
//   rdata holds prior value, then GRANT accepts, rdata valid next cycle;
//   stall_cycles=2.
// - ren+we same cycle, same word, old 32'h1, new 32'h2 -> rdata=32'h1;
//   next read -> 32'h2.
// - rst_n=0 during STALL -> next cycle stall=0, rdata=0, stall_cycles=0.

Source files
------------

// File: rtl/svc_rv_dmem_if.sv
// svc_rv dmem port bundle: read/write request, read data and stall.
// master = core side, slave = memory responder side.
interface svc_rv_dmem_if;
  logic        dmem_ren;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_stall;

  modport master (
    output dmem_ren,
    output dmem_raddr,
    output dmem_we,
    output dmem_waddr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_rdata,
    input  dmem_stall
  );

  modport slave (
    input  dmem_ren,
    input  dmem_raddr,
    input  dmem_we,
    input  dmem_waddr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_rdata,
    output dmem_stall
  );
endinterface

// File: rtl/svc_rv_dmem_resp.sv
// Data-memory responder: word RAM, 1-cycle registered read, LFSR stalls.
// Ports: clk, rst_n (sync, low), stall_en, dmem (slave), stall_cycles.
module svc_rv_dmem_resp #(
  parameter int          AW        = 10,
  parameter int          MAX_STALL = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_en,
  svc_rv_dmem_if.slave        dmem,
  output logic [15:0]         stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    GRANT
  } state_t;

  localparam logic [2:0] MAXS = 3'(MAX_STALL);

  state_t          state;
  logic [1:0]      cnt;
  logic [15:0]     lfsr;
  logic [31:0]     mem [2**AW];

  logic            req;
  logic            pick;
  logic [2:0]      len_raw;
  logic [2:0]      len;
  logic            stall;
  logic            rd_acc;
  logic            wr_acc;
  logic            fb;
  logic [AW-1:0]   ridx;
  logic [AW-1:0]   widx;
  logic            unused_addr;

  assign req  = dmem.dmem_ren | dmem.dmem_we;
  assign ridx = dmem.dmem_raddr[AW+1:2];
  assign widx = dmem.dmem_waddr[AW+1:2];
  assign fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Byte offset and high address bits alias onto the same word.
  assign unused_addr = ^{dmem.dmem_raddr[31:AW+2],
                         dmem.dmem_raddr[1:0],
                         dmem.dmem_waddr[31:AW+2],
                         dmem.dmem_waddr[1:0]};

  always_comb begin
    pick    = stall_en & lfsr[0];
    len_raw = {1'b0, lfsr[2:1]} + 3'd1;
    len     = (len_raw > MAXS) ? MAXS : len_raw;
    stall   = 1'b0;
    unique case (state)
      IDLE:    stall = req & pick;
      STALL:   stall = 1'b1;
      GRANT:   stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  assign rd_acc          = dmem.dmem_ren & ~stall;
  assign wr_acc          = dmem.dmem_we & ~stall;
  assign dmem.dmem_stall = stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      lfsr            <= LFSR_SEED;
      dmem.dmem_rdata <= 32'd0;
      stall_cycles    <= 16'd0;
    end else begin
      lfsr <= {fb, lfsr[15:1]};
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      // Nonblocking read of the old word gives read-first on collisions.
      if (rd_acc)
        dmem.dmem_rdata <= mem[ridx];
      unique case (state)
        IDLE: begin
          if (stall) begin
            cnt   <= 2'(len - 3'd1);
            state <= (len == 3'd1) ? GRANT : STALL;
          end
        end
        STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1)
            state <= GRANT;
        end
        GRANT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem.dmem_wstrb[i])
          mem[widx][8*i +: 8] <= dmem.dmem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Bench for svc_rv_dmem_resp: directed cases plus random traffic
// compared every cycle against a queue/array level model.
module tb_svc_rv_dmem_resp;

  localparam int          AW   = 10;
  localparam int          MAXS = 2;
  localparam logic [15:0] SEED = 16'hACE3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_en;
  logic [15:0] stall_cycles;

  svc_rv_dmem_if bus();

  svc_rv_dmem_resp #(
    .AW(AW),
    .MAX_STALL(MAXS),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_en(stall_en),
    .dmem(bus),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  // Reference model state.
  logic [31:0] m_mem [2**AW];
  int          m_lfsr;
  int          m_left;
  bit          m_grant;
  logic [31:0] m_rdata;
  int          m_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit req;
    req = bus.dmem_ren | bus.dmem_we;
    if (m_grant) return 1'b0;
    if (m_left > 0) return 1'b1;
    return req & stall_en & m_lfsr[0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_lfsr  = int'(SEED);
        m_left  = 0;
        m_grant = 0;
        m_rdata = 32'd0;
        m_cnt   = 0;
      end else begin
        bit s;
        int ri;
        int wi;
        int ln;
        int f;
        s  = m_stall();
        ri = (bus.dmem_raddr >> 2) % (2**AW);
        wi = (bus.dmem_waddr >> 2) % (2**AW);
        if (s && m_cnt < 65535) m_cnt++;
        if (!s && bus.dmem_ren) m_rdata = m_mem[ri];
        if (!s && bus.dmem_we)
          for (int i = 0; i < 4; i++)
            if (bus.dmem_wstrb[i])
              m_mem[wi][8*i +: 8] = bus.dmem_wdata[8*i +: 8];
        if (m_grant) begin
          m_grant = 0;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_grant = 1;
        end else if (s) begin
          ln = ((m_lfsr >> 1) & 3) + 1;
          if (ln > MAXS) ln = MAXS;
          m_left = ln - 1;
          if (m_left == 0) m_grant = 1;
        end
        f = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (f << 15);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("cyc_stall", {31'd0, bus.dmem_stall}, {31'd0, m_stall()});
        chk("cyc_rdata", bus.dmem_rdata, m_rdata);
        chk("cyc_stall_cycles", {16'd0, stall_cycles}, 32'(m_cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.dmem_ren   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_raddr = 32'd0;
    bus.dmem_waddr = 32'd0;
    bus.dmem_wdata = 32'd0;
    bus.dmem_wstrb = 4'h0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bus.dmem_we    = 1'b1;
    bus.dmem_waddr = a;
    bus.dmem_wdata = d;
    bus.dmem_wstrb = s;
    tick();
    bus.dmem_we = 1'b0;
  endtask

  task automatic rd(logic [31:0] a);
    bus.dmem_ren   = 1'b1;
    bus.dmem_raddr = a;
    tick();
    bus.dmem_ren = 1'b0;
  endtask

  initial begin
    bit st;
    rst_n    = 1'b0;
    stall_en = 1'b0;
    idle_in();
    tick();
    tick();
    chk_on = 1;
    chk("reset_rdata", bus.dmem_rdata, 32'd0);
    chk("reset_stall", {31'd0, bus.dmem_stall}, 32'd0);
    chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 2**AW; i++)
      wr(32'(i) << 2, $urandom, 4'hF);

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    bus.dmem_ren   = 1'b1;
    bus.dmem_raddr = 32'h10;
    #1;
    chk("plain_no_stall", {31'd0, bus.dmem_stall}, 32'd0);
    tick();
    bus.dmem_ren = 1'b0;
    chk("plain_read", bus.dmem_rdata, 32'hDEADBEEF);

    wr(32'h20, 32'h0, 4'hF);
    wr(32'h20, 32'h11223344, 4'b0101);
    rd(32'h20);
    chk("byte_strobe", bus.dmem_rdata, 32'h00220044);

    wr(32'h10, 32'hCAFEF00D, 4'hF);
    rd(32'h1010);
    chk("alias_high", bus.dmem_rdata, 32'hCAFEF00D);
    rd(32'h13);
    chk("alias_low", bus.dmem_rdata, 32'hCAFEF00D);

    wr(32'h30, 32'h1, 4'hF);
    bus.dmem_ren   = 1'b1;
    bus.dmem_raddr = 32'h30;
    wr(32'h30, 32'h2, 4'hF);
    bus.dmem_ren = 1'b0;
    chk("read_first", bus.dmem_rdata, 32'h1);
    rd(32'h30);
    chk("read_after_write", bus.dmem_rdata, 32'h2);

    // Seed ACE3: pick=1, len=2 on the first cycle after reset.
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    stall_en       = 1'b1;
    bus.dmem_ren   = 1'b1;
    bus.dmem_raddr = 32'h10;
    #1;
    chk("stall_c1", {31'd0, bus.dmem_stall}, 32'd1);
    tick();
    chk("stall_c2", {31'd0, bus.dmem_stall}, 32'd1);
    chk("stall_hold_rdata", bus.dmem_rdata, 32'd0);
    tick();
    chk("grant_no_stall", {31'd0, bus.dmem_stall}, 32'd0);
    chk("grant_hold_rdata", bus.dmem_rdata, 32'd0);
    tick();
    bus.dmem_ren = 1'b0;
    stall_en     = 1'b0;
    chk("grant_rdata", bus.dmem_rdata, 32'hCAFEF00D);
    chk("stall_count", {16'd0, stall_cycles}, 32'd2);
    tick();

    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    stall_en       = 1'b1;
    bus.dmem_ren   = 1'b1;
    bus.dmem_raddr = 32'h10;
    tick();
    chk("mid_stall", {31'd0, bus.dmem_stall}, 32'd1);
    rst_n        = 1'b0;
    bus.dmem_ren = 1'b0;
    tick();
    chk("rst_mid_stall", {31'd0, bus.dmem_stall}, 32'd0);
    chk("rst_mid_rdata", bus.dmem_rdata, 32'd0);
    chk("rst_mid_count", {16'd0, stall_cycles}, 32'd0);
    rst_n = 1'b1;
    tick();

    st = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      st = bus.dmem_stall;
      @(posedge clk);
      #1;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        idle_in();
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 9) == 0) stall_en = ~stall_en;
        if (!st || $urandom_range(0, 49) == 0) begin
          logic [31:0] ra;
          logic [31:0] wa;
          ra = $urandom;
          ra[11:2] = 10'($urandom_range(0, 15));
          wa = $urandom;
          wa[11:2] = ($urandom_range(0, 3) == 0) ?
                     ra[11:2] : 10'($urandom_range(0, 15));
          bus.dmem_ren   = ($urandom_range(0, 2) != 0);
          bus.dmem_raddr = ra;
          bus.dmem_we    = ($urandom_range(0, 2) == 0);
          bus.dmem_waddr = wa;
          bus.dmem_wdata = $urandom;
          bus.dmem_wstrb = 4'($urandom);
        end
      end
    end
    idle_in();
    rst_n = 1'b1;
    tick();
    tick();
    chk_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
